// File: rtl/id_hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the decode-stage hazard controller.
package id_hazard_stall_unit_pkg;

  typedef enum logic {RUN, STALL} stall_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam logic [1:0] NO_STALL       = 2'd0;
  localparam logic [1:0] LOAD_USE_STALL = 2'd2;
  localparam logic [1:0] ALU_USE_STALL  = 2'd1;
  localparam logic [1:0] LOAD_MEM_STALL = 2'd1;

  // A write to $zero is architecturally discarded, so it never creates a dependency.
  function automatic logic src_hit(input logic valid, input logic uses,
                                   input logic [4:0] src, input logic [4:0] rd);
    return valid & uses & (src == rd) & (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/id_hazard_stall_unit_if.sv
// Decode-stage hazard bus: ID operands, downstream latch info, control and counters.
interface id_hazard_stall_unit_if #(parameter int unsigned CNT_W = 32);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_branch_taken;
  logic [4:0]       idex_rd;
  logic             idex_reg_write;
  logic             idex_mem_read;
  logic [4:0]       exm_rd;
  logic             exm_mem_read;
  logic             freeze;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] hazard_events;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
           idex_rd, idex_reg_write, idex_mem_read, exm_rd, exm_mem_read, freeze,
    input  pc_write_en, ifid_write_en, idex_bubble, ifid_flush,
           stall_cycles, hazard_events, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
           idex_rd, idex_reg_write, idex_mem_read, exm_rd, exm_mem_read, freeze,
    output pc_write_en, ifid_write_en, idex_bubble, ifid_flush,
           stall_cycles, hazard_events, flush_count
  );
endinterface

// File: rtl/id_hazard_stall_unit_hazard_perf_counters.sv
// Wrapping hazard performance counters; all counting is suspended while frozen.
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             stall_en,
  input  logic             hazard_en,
  input  logic             flush_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_events,
  output logic [CNT_W-1:0] flush_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      hazard_events <= '0;
      flush_count   <= '0;
    end else if (!freeze) begin
      if (stall_en)  stall_cycles  <= stall_cycles + 1'b1;
      if (hazard_en) hazard_events <= hazard_events + 1'b1;
      if (flush_en)  flush_count   <= flush_count + 1'b1;
    end
  end

endmodule

// File: rtl/id_hazard_stall_unit.sv
// ID-stage stall/flush controller: holds the front end until operands become forwardable.
module id_hazard_stall_unit
  import id_hazard_stall_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  id_hazard_stall_unit_if.slave hz
);

  stall_state_t state, state_next;
  logic [1:0]   remain, remain_next, need;
  logic         stall, hazard_new;
  logic         hit_idex, hit_exm;

  always_comb begin
    hit_idex = src_hit(hz.id_valid, hz.id_uses_rs, hz.id_rs, hz.idex_rd)
             | src_hit(hz.id_valid, hz.id_uses_rt, hz.id_rt, hz.idex_rd);
    hit_exm  = src_hit(hz.id_valid, hz.id_uses_rs, hz.id_rs, hz.exm_rd)
             | src_hit(hz.id_valid, hz.id_uses_rt, hz.id_rt, hz.exm_rd);
    need = NO_STALL;
    if (hit_idex && hz.idex_reg_write && hz.idex_mem_read) need = LOAD_USE_STALL;
    else if (hit_idex && hz.idex_reg_write)                need = ALU_USE_STALL;
    else if (hit_exm && hz.exm_mem_read)                   need = LOAD_MEM_STALL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      remain <= '0;
    end else begin
      state  <= state_next;
      remain <= remain_next;
    end
  end

  // The first stall cycle is spent in RUN, so STALL only covers the remainder.
  always_comb begin
    state_next  = state;
    remain_next = remain;
    stall       = 1'b0;
    hazard_new  = 1'b0;
    case (state)
      RUN: begin
        if (need != NO_STALL) begin
          stall = 1'b1;
          if (!hz.freeze) begin
            hazard_new  = 1'b1;
            remain_next = need - 2'd1;
            state_next  = (need - 2'd1 != 2'd0) ? STALL : RUN;
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        if (!hz.freeze) begin
          remain_next = remain - 2'd1;
          if (remain == 2'd1) state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    hz.pc_write_en   = 1'b1;
    hz.ifid_write_en = 1'b1;
    hz.idex_bubble   = 1'b0;
    hz.ifid_flush    = 1'b0;
    if (reset) begin
      hz.pc_write_en   = 1'b0;
      hz.ifid_write_en = 1'b0;
      hz.idex_bubble   = 1'b1;
    end else if (hz.freeze) begin
      hz.pc_write_en   = 1'b0;
      hz.ifid_write_en = 1'b0;
    end else if (stall) begin
      hz.pc_write_en   = 1'b0;
      hz.ifid_write_en = 1'b0;
      hz.idex_bubble   = 1'b1;
    end else begin
      hz.ifid_flush    = hz.id_branch_taken;
    end
  end

  hazard_perf_counters #(.CNT_W(CNT_W)) u_counters (
    .clk           (clk),
    .rst           (reset),
    .freeze        (hz.freeze),
    .stall_en      (stall),
    .hazard_en     (hazard_new),
    .flush_en      (hz.id_branch_taken & ~stall),
    .stall_cycles  (hz.stall_cycles),
    .hazard_events (hz.hazard_events),
    .flush_count   (hz.flush_count)
  );

endmodule

// File: tb/tb_id_hazard_stall_unit.sv
// Directed bench for id_hazard_stall_unit with an expectation queue per cycle.
module tb_id_hazard_stall_unit;

  localparam int unsigned CNT_W = 32;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  typedef struct {
    string            tag;
    logic             pc;
    logic             ifid;
    logic             bubble;
    logic             flush;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] he;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t exp_q[$];

  id_hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  id_hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, observed running required done");
    $fatal(1, "timeout");
  end

  task automatic clear_in();
    bus.id_valid        = 1'b0;
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.idex_rd         = 5'd0;
    bus.idex_reg_write  = 1'b0;
    bus.idex_mem_read   = 1'b0;
    bus.exm_rd          = 5'd0;
    bus.exm_mem_read    = 1'b0;
    bus.freeze          = 1'b0;
  endtask

  task automatic consumer_rs(input logic [4:0] r);
    bus.id_valid   = 1'b1;
    bus.id_rs      = r;
    bus.id_uses_rs = 1'b1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic req);
    total++;
    assert (obs === req) passed++;
    else $error("FAIL %s observed=%b required=%b", tag, obs, req);
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs,
                           input logic [CNT_W-1:0] req);
    total++;
    assert (obs === req) passed++;
    else $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
  endtask

  // Expectation for the current cycle: outputs are sampled on the falling edge.
  task automatic step(input string tag, input logic pc, input logic ifid,
                      input logic bubble, input logic flush,
                      input int sc, input int he, input int fc);
    exp_t e;
    exp_t g;
    e.tag = tag; e.pc = pc; e.ifid = ifid; e.bubble = bubble; e.flush = flush;
    e.sc = CNT_W'(sc); e.he = CNT_W'(he); e.fc = CNT_W'(fc);
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check_bit({g.tag, ".pc_write_en"},   bus.pc_write_en,   g.pc);
    check_bit({g.tag, ".ifid_write_en"}, bus.ifid_write_en, g.ifid);
    check_bit({g.tag, ".idex_bubble"},   bus.idex_bubble,   g.bubble);
    check_bit({g.tag, ".ifid_flush"},    bus.ifid_flush,    g.flush);
    check_cnt({g.tag, ".stall_cycles"},  bus.stall_cycles,  g.sc);
    check_cnt({g.tag, ".hazard_events"}, bus.hazard_events, g.he);
    check_cnt({g.tag, ".flush_count"},   bus.flush_count,   g.fc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    clear_in();
    step("reset", 0, 0, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("idle", 1, 1, 0, 0, 0, 0, 0);

    // load in ID/EX, consumer reads rs: two stall cycles
    consumer_rs(5'd8);
    bus.idex_rd = 5'd8; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    step("lu_s1", 0, 0, 1, 0, 0, 0, 0);
    step("lu_s2", 0, 0, 1, 0, 1, 1, 0);
    clear_in(); consumer_rs(5'd8);
    step("lu_done", 1, 1, 0, 0, 2, 1, 0);

    // ALU result in ID/EX, consumer reads rt: one stall cycle
    clear_in();
    bus.id_valid = 1'b1; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
    bus.idex_rd = 5'd9; bus.idex_reg_write = 1'b1;
    step("alu_s1", 0, 0, 1, 0, 2, 1, 0);
    clear_in();
    step("alu_done", 1, 1, 0, 0, 3, 2, 0);
    consumer_rs(5'd0);
    bus.idex_rd = 5'd0; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    step("zero_dest", 1, 1, 0, 0, 3, 2, 0);

    // load two ahead in EX/MEM: one stall cycle
    clear_in(); consumer_rs(5'd10);
    bus.exm_rd = 5'd10; bus.exm_mem_read = 1'b1;
    step("exm_s1", 0, 0, 1, 0, 3, 2, 0);
    clear_in();
    step("exm_done", 1, 1, 0, 0, 4, 3, 0);
    consumer_rs(5'd10);
    bus.exm_rd = 5'd10; bus.idex_rd = 5'd10;
    step("no_loads", 1, 1, 0, 0, 4, 3, 0);

    // taken branch without and with a hazard
    clear_in(); bus.id_branch_taken = 1'b1;
    step("br_flush", 1, 1, 0, 1, 4, 3, 0);
    clear_in();
    step("br_after", 1, 1, 0, 0, 4, 3, 1);
    consumer_rs(5'd8); bus.id_branch_taken = 1'b1;
    bus.idex_rd = 5'd8; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    step("br_lu_s1", 0, 0, 1, 0, 4, 3, 1);
    step("br_lu_s2", 0, 0, 1, 0, 5, 4, 1);
    clear_in(); bus.id_branch_taken = 1'b1;
    step("br_reresolve", 1, 1, 0, 1, 6, 4, 1);
    clear_in();
    step("br_after2", 1, 1, 0, 0, 6, 4, 2);

    // freeze during the second stall cycle suspends the countdown
    consumer_rs(5'd8);
    bus.idex_rd = 5'd8; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    step("fz_s1", 0, 0, 1, 0, 6, 4, 2);
    bus.freeze = 1'b1;
    step("fz_hold1", 0, 0, 0, 0, 7, 5, 2);
    step("fz_hold2", 0, 0, 0, 0, 7, 5, 2);
    step("fz_hold3", 0, 0, 0, 0, 7, 5, 2);
    clear_in();
    step("fz_s2", 0, 0, 1, 0, 7, 5, 2);
    step("fz_done", 1, 1, 0, 0, 8, 5, 2);
    bus.freeze = 1'b1; bus.id_branch_taken = 1'b1;
    step("fz_branch", 0, 0, 0, 0, 8, 5, 2);
    clear_in();
    step("fz_branch_after", 1, 1, 0, 0, 8, 5, 2);

    // reset arriving mid-stall aborts it
    consumer_rs(5'd8);
    bus.idex_rd = 5'd8; bus.idex_reg_write = 1'b1; bus.idex_mem_read = 1'b1;
    step("rst_s1", 0, 0, 1, 0, 8, 5, 2);
    clear_in();
    reset = 1'b1;
    #1;
    step("rst_mid", 0, 0, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step("rst_after", 1, 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_hazard_stall_unit.md
# id_hazard_stall_unit

Decode-stage hazard controller for the 5-stage MIPS pipeline. It is the stall/flush side of the ID-stage bypass network: the ID forwarding unit resolves operands available in the EX/MEM and MEM/WB latches, and this unit holds the front end until every other operand becomes forwardable. It also flushes IF/ID on a taken branch or jump resolved in ID, and keeps hazard performance counters for the debug unit.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction (not a bubble)
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  instruction in ID reads rs
- id_uses_rt  in  1  instruction in ID reads rt
- id_branch_taken  in  1  branch or jump resolved taken in ID this cycle
- idex_rd  in  5  destination register in the ID/EX latch
- idex_reg_write  in  1  ID/EX instruction writes a register
- idex_mem_read  in  1  ID/EX instruction is a load
- exm_rd  in  5  destination register in the EX/MEM latch
- exm_mem_read  in  1  EX/MEM instruction is a load
- freeze  in  1  debug-unit hold request
- pc_write_en  out  1  PC may update
- ifid_write_en  out  1  IF/ID latch may update
- idex_bubble  out  1  load NOP control into ID/EX
- ifid_flush  out  1  clear IF/ID to NOP
- stall_cycles  out  CNT_W  cycles spent stalled for data hazards
- hazard_events  out  CNT_W  distinct hazards detected
- flush_count  out  CNT_W  IF/ID flushes issued

## Operation
- Source match: `rs_hit(rd) = id_valid & id_uses_rs & (id_rs == rd) & (rd != 0)`. `rt_hit` is the same for rt. `hit(rd) = rs_hit | rt_hit`.
- Required stall length `need`, evaluated in priority order:
  - 2 if `hit(idex_rd) & idex_reg_write & idex_mem_read` (load in ID/EX).
  - 1 if `hit(idex_rd) & idex_reg_write` (ALU result in ID/EX).
  - 1 if `hit(exm_rd) & exm_mem_read` (load data not yet in MEM/WB).
  - 0 otherwise.
- FSM states:
  - RUN: if `need != 0` and `!freeze`, stall this cycle. Load `remain = need-1`, increment hazard_events, go to STALL if `remain != 0`, otherwise stay in RUN.
  - STALL: stall unconditionally. Decrement `remain`. Return to RUN when `remain` reaches 0.
- Hazards are not re-detected while in STALL.
- stall = (state == STALL) | (RUN & need != 0).
- When stall is asserted: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0.
- Flush: `ifid_flush = id_branch_taken & !stall & !freeze`. PC and IF/ID still write, and the flushed slot becomes a NOP. Increment flush_count.
- Freeze:
  - pc_write_en=0, ifid_write_en=0, idex_bubble=0, ifid_flush=0.
  - FSM state, `remain` and all counters hold.
  - A freeze arriving during STALL suspends the countdown and resumes it afterwards.
- Counters increment only on cycles that are not frozen. stall_cycles increments on every stall cycle. All counters wrap modulo 2^CNT_W.
- When freeze=0 and stall=0: pc_write_en=1, ifid_write_en=1, idex_bubble=0.

## Timing
- Stall and flush outputs are combinational from the current inputs and state. They take effect on the same edge as the hazard.
- State, `remain` and counters update on the rising edge of clk.
- Load→dependent: exactly 2 stall cycles. ALU→dependent: exactly 1 stall cycle. Load two ahead: exactly 1 stall cycle.
- A simultaneous hazard and taken branch give a stall with no flush. The branch re-resolves after the stall.
- Reset is asynchronous and clears state to RUN, `remain` to 0 and all counters to 0.
- While reset is asserted: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0.
- A reset asserted mid-STALL aborts the stall immediately.

## Structure
- Shared pipeline package holds:
  - the FSM state enum (RUN, STALL),
  - the register-zero constant,
  - the stall-length constants (LOAD_USE_STALL=2, ALU_USE_STALL=1, LOAD_MEM_STALL=1).
- One natural sub-module: `hazard_perf_counters`. It holds the three wrapping counters, with enable inputs and a freeze gate.

## Test plan
- lw $t0 in ID/EX with an ID consumer reading rs=$t0 → 2 stall cycles, hazard_events=1, stall_cycles=2. The consumer then forwards via the MEM/WB load path.
- add $t1 in ID/EX with an ID consumer reading rt=$t1 → exactly 1 stall cycle. A destination of $zero gives no stall.
- Load in EX/MEM (rd=$t2) with an ID consumer of $t2 → 1 stall cycle. With idex_mem_read=0 and exm_mem_read=0 the unit issues no stall.
- id_branch_taken=1 with no hazard → ifid_flush=1 for 1 cycle and flush_count=1. Taken branch with a simultaneous load-use hazard → stall, no flush.
- freeze=1 raised during the second stall cycle for 3 cycles → all write enables 0, `remain` and counters hold. The stall finishes after release, and stall_cycles=2.
- Reset asserted mid-STALL → outputs at reset values immediately, counters 0. After deassertion with no hazard: pc_write_en=1.
